// File: rtl/stream_mux_rr.sv
// ----------------------------------------------------------------------------
// stream_mux_rr
//
// Packet-aware N-channel stream multiplexer with one registered output stage.
// A channel is chosen in IDLE, either from the static `sel` input (mode=0) or
// by round-robin search starting after the previously served channel
// (mode=1). The grant is held until the beat carrying `last` is accepted.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   mode       0 = static select via sel, 1 = round-robin
//   sel        channel index used in static mode
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel beat valid
//   in_last    per-channel last beat of packet
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered output data
//   out_valid  registered output valid
//   out_last   registered last flag
//   out_ready  downstream ready
//   out_ch     channel index of the beat currently on out_data
//   busy       high while a packet grant is held
// ----------------------------------------------------------------------------
module stream_mux_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] grant_ch;
  logic [SEL_W-1:0] ptr;

  // Unpacked view of the channel data bus.
  logic [WIDTH-1:0] ch_data [N_CH];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin search. Offsets are walked from the farthest to the nearest
  // so the last hit, i.e. the channel closest after ptr, wins. The explicit
  // modulo keeps the wrap correct for non-power-of-2 channel counts.
  logic [SEL_W-1:0] rr_idx;
  logic             rr_found;
  logic [SEL_W-1:0] rr_probe;

  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    rr_probe = '0;
    for (int k = N_CH; k >= 1; k--) begin
      rr_probe = SEL_W'((int'(ptr) + k) % N_CH);
      if (in_valid[rr_probe]) begin
        rr_found = 1'b1;
        rr_idx   = rr_probe;
      end
    end
  end

  // Static selection; an out-of-range index never grants.
  logic sel_ok;

  always_comb begin
    sel_ok = 1'b0;
    if (int'(sel) < N_CH) begin
      sel_ok = in_valid[sel];
    end
  end

  logic             grant_now;
  logic [SEL_W-1:0] grant_idx;

  always_comb begin
    grant_now = mode ? rr_found : sel_ok;
    grant_idx = mode ? rr_idx : sel;
  end

  // Ready follows downstream space, so a drain and a refill can share a cycle.
  logic space;
  logic accept;

  always_comb begin
    space    = !out_valid || out_ready;
    in_ready = '0;
    if (state == LOCKED) begin
      in_ready[grant_ch] = space;
    end
    accept = (state == LOCKED) && in_valid[grant_ch] && space;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_ch  <= '0;
      ptr       <= SEL_W'(N_CH - 1);
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_ch    <= '0;
      busy      <= 1'b0;
    end else begin
      // Output register: load on accept, otherwise drain when taken.
      if (accept) begin
        out_data  <= ch_data[grant_ch];
        out_last  <= in_last[grant_ch];
        out_ch    <= grant_ch;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (grant_now) begin
            grant_ch <= grant_idx;
            busy     <= 1'b1;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && in_last[grant_ch]) begin
            ptr   <= grant_ch;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// ----------------------------------------------------------------------------
// tb_stream_mux_rr
//
// Directed bench for stream_mux_rr (N_CH=4, WIDTH=8). Each scenario task
// drives its own stimulus and compares outputs against hand-derived values.
// ----------------------------------------------------------------------------
module tb_stream_mux_rr;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           mode;
  logic [1:0]     sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_last;
  logic           out_ready;
  logic [1:0]     out_ch;
  logic           busy;

  int total;
  int bad;

  stream_mux_rr #(.N_CH(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .sel(sel),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_last(out_last),
    .out_ready(out_ready),
    .out_ch(out_ch),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [W-1:0] v);
    in_data[ch*W +: W] = v;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = 2'd3;
    in_data   = 32'h44332211;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    step();
    step();
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (in_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=0000", in_ready);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b want=0", busy);
    end
    total++;
    if (out_data !== 8'h00 || out_ch !== 2'd0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_regs got data=%h ch=%0d last=%b want 00/0/0",
               out_data, out_ch, out_last);
    end
    rst_n = 1'b1;
    step();  // grant decision
    total++;
    if (busy !== 1'b1 || in_ready !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_grant got busy=%b in_ready=%b want 1/0001",
               busy, in_ready);
    end
    step();  // accept single-beat packet from ch0
    $display("beat ch=%0d data=%h last=%b", out_ch, out_data, out_last);
    total++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h11) begin
      bad++;
      $display("FAIL reset_first_beat got valid=%b ch=%0d data=%h want 1/0/11",
               out_valid, out_ch, out_data);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_rr_fairness();
    int cnt [N];
    int got [$];
    int exp_seq [10];
    logic [N-1:0] acc;
    exp_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    for (int i = 0; i < N; i++) cnt[i] = 0;
    do_reset();
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got.size() < 10; c++) begin
      for (int i = 0; i < N; i++) begin
        in_last[i] = (cnt[i] == 1);
        set_data(i, 8'(i * 16 + cnt[i]));
      end
      #1;
      acc = in_valid & in_ready;
      step();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) cnt[i] = (cnt[i] + 1) % 2;
      end
      if (acc != '0) begin
        got.push_back(int'(out_ch));
        $display("beat ch=%0d data=%h last=%b", out_ch, out_data, out_last);
      end
    end
    total++;
    if (got.size() != 10) begin
      bad++;
      $display("FAIL rr_beat_count got=%0d want=10", got.size());
    end
    for (int k = 0; k < 10 && k < got.size(); k++) begin
      total++;
      if (got[k] != exp_seq[k]) begin
        bad++;
        $display("FAIL rr_order[%0d] got ch=%0d want ch=%0d", k, got[k], exp_seq[k]);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_static_select();
    do_reset();
    mode      = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'b1111;
    in_last   = 4'b0000;
    out_ready = 1'b1;
    set_data(0, 8'h11);
    set_data(1, 8'h22);
    set_data(2, 8'hA5);
    set_data(3, 8'h44);
    step();  // grant ch2
    total++;
    if (busy !== 1'b1 || in_ready !== 4'b0100) begin
      bad++;
      $display("FAIL static_grant got busy=%b in_ready=%b want 1/0100", busy, in_ready);
    end
    step();  // accept A5
    $display("beat ch=%0d data=%h last=%b", out_ch, out_data, out_last);
    set_data(2, 8'h3C);
    in_last[2] = 1'b1;
    #1;
    total++;
    if (out_data !== 8'hA5 || out_ch !== 2'd2 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL static_beat0 got data=%h ch=%0d last=%b want A5/2/0",
               out_data, out_ch, out_last);
    end
    total++;
    if (in_ready !== 4'b0100) begin
      bad++;
      $display("FAIL static_ready_mid got=%b want=0100", in_ready);
    end
    step();  // accept 3C with last
    $display("beat ch=%0d data=%h last=%b", out_ch, out_data, out_last);
    in_valid = 4'b1011;  // selected channel goes quiet
    #1;
    total++;
    if (out_data !== 8'h3C || out_ch !== 2'd2 || out_last !== 1'b1) begin
      bad++;
      $display("FAIL static_beat1 got data=%h ch=%0d last=%b want 3C/2/1",
               out_data, out_ch, out_last);
    end
    total++;
    if (busy !== 1'b0 || in_ready !== 4'b0000) begin
      bad++;
      $display("FAIL static_release got busy=%b in_ready=%b want 0/0000", busy, in_ready);
    end
    step();
    step();
    step();
    total++;
    if (busy !== 1'b0 || in_ready !== 4'b0000 || out_valid !== 1'b0 || out_data !== 8'h3C) begin
      bad++;
      $display("FAIL static_invalid_sel got busy=%b in_ready=%b valid=%b data=%h want 0/0000/0/3C",
               busy, in_ready, out_valid, out_data);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [W-1:0] beats [4];
    logic [W-1:0] got [$];
    logic [W-1:0] held;
    logic         stalled;
    logic         acc;
    logic         cons;
    logic         pat [6];
    int           idx;
    beats = '{8'h10, 8'h11, 8'h12, 8'h13};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    idx   = 0;
    held  = '0;
    do_reset();
    mode     = 1'b0;
    sel      = 2'd1;
    in_valid = 4'b0010;
    for (int c = 0; c < 30 && got.size() < 4; c++) begin
      out_ready  = (c < 6) ? pat[c] : 1'b1;
      in_valid   = (idx < 4) ? 4'b0010 : 4'b0000;
      set_data(1, beats[(idx < 4) ? idx : 3]);
      in_last[1] = (idx == 3);
      #1;
      stalled = out_valid && !out_ready;
      if (stalled) begin
        held = out_data;
        total++;
        if (in_ready[1] !== 1'b0) begin
          bad++;
          $display("FAIL bp_ready_stall cycle=%0d got=%b want=0", c, in_ready[1]);
        end
      end
      acc  = in_valid[1] && in_ready[1];
      cons = out_valid && out_ready;
      if (cons) begin
        got.push_back(out_data);
        $display("beat ch=%0d data=%h last=%b", out_ch, out_data, out_last);
      end
      step();
      if (acc) idx++;
      if (stalled) begin
        total++;
        if (out_data !== held || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL bp_hold cycle=%0d got data=%h valid=%b want %h/1",
                   c, out_data, out_valid, held);
        end
      end
    end
    total++;
    if (got.size() != 4) begin
      bad++;
      $display("FAIL bp_count got=%0d want=4", got.size());
    end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      total++;
      if (got[k] !== beats[k]) begin
        bad++;
        $display("FAIL bp_data[%0d] got=%h want=%h", k, got[k], beats[k]);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_packet_lock();
    do_reset();
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b0001;
    in_last   = 4'b0000;
    set_data(0, 8'h00);
    set_data(3, 8'h33);
    step();  // grant ch0
    for (int b = 0; b < 3; b++) begin
      set_data(0, 8'(8'hB0 + b));
      step();
      $display("beat ch=%0d data=%h last=%b", out_ch, out_data, out_last);
    end
    in_valid   = 4'b1001;
    in_last[3] = 1'b1;
    set_data(0, 8'hB3);
    #1;
    total++;
    if (in_ready !== 4'b0001) begin
      bad++;
      $display("FAIL lock_ready_mid got=%b want=0001", in_ready);
    end
    step();  // beat 3
    $display("beat ch=%0d data=%h last=%b", out_ch, out_data, out_last);
    in_last[0] = 1'b1;
    set_data(0, 8'hB4);
    #1;
    total++;
    if (out_ch !== 2'd0 || busy !== 1'b1 || in_ready !== 4'b0001) begin
      bad++;
      $display("FAIL lock_hold got ch=%0d busy=%b in_ready=%b want 0/1/0001",
               out_ch, busy, in_ready);
    end
    step();  // beat 4, last
    $display("beat ch=%0d data=%h last=%b", out_ch, out_data, out_last);
    in_valid[0] = 1'b0;
    #1;
    total++;
    if (out_ch !== 2'd0 || out_last !== 1'b1 || out_data !== 8'hB4 || busy !== 1'b0) begin
      bad++;
      $display("FAIL lock_last got ch=%0d last=%b data=%h busy=%b want 0/1/B4/0",
               out_ch, out_last, out_data, busy);
    end
    step();  // grant ch3
    total++;
    if (busy !== 1'b1 || in_ready !== 4'b1000) begin
      bad++;
      $display("FAIL lock_next_grant got busy=%b in_ready=%b want 1/1000", busy, in_ready);
    end
    step();
    $display("beat ch=%0d data=%h last=%b", out_ch, out_data, out_last);
    total++;
    if (out_ch !== 2'd3 || out_data !== 8'h33) begin
      bad++;
      $display("FAIL lock_next_beat got ch=%0d data=%h want 3/33", out_ch, out_data);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_async_reset();
    do_reset();
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b0100;
    in_last   = 4'b0000;
    set_data(2, 8'h77);
    step();  // grant ch2
    step();  // accept a beat
    total++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || out_ch !== 2'd2) begin
      bad++;
      $display("FAIL arst_pre got valid=%b busy=%b ch=%0d want 1/1/2",
               out_valid, busy, out_ch);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 4'b0000) begin
      bad++;
      $display("FAIL arst_immediate got valid=%b busy=%b in_ready=%b want 0/0/0000",
               out_valid, busy, in_ready);
    end
    step();
    step();
    rst_n    = 1'b1;
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    set_data(0, 8'h5A);
    step();  // grant
    step();  // accept
    $display("beat ch=%0d data=%h last=%b", out_ch, out_data, out_last);
    total++;
    if (out_ch !== 2'd0 || out_data !== 8'h5A) begin
      bad++;
      $display("FAIL arst_restart got ch=%0d data=%h want 0/5A", out_ch, out_data);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b0;
    test_reset();
    test_rr_fairness();
    test_static_select();
    test_backpressure();
    test_packet_lock();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel streaming multiplexer. Each channel carries WIDTH-bit data with valid/ready/last handshakes.
- Channels are selected by a static `sel` input or by round-robin arbitration. The grant is held for a whole packet, ending on `last`.
- A single registered output stage sits between the channel sources and one downstream sink.
- It is the clocked, packet-aware successor to the combinational 4:1 select tree.

Parameters:
- N_CH, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel in bits.
- SEL_W, clog2(N_CH), width of channel index signals (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = static select via `sel`, 1 = round-robin.
- sel  in  SEL_W  channel index used in static mode.
- in_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
- in_valid  in  N_CH  per-channel beat valid.
- in_last  in  N_CH  per-channel last beat of packet.
- in_ready  out  N_CH  per-channel ready; at most one bit high.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  registered output valid.
- out_last  out  1  registered last flag.
- out_ready  in  1  downstream ready.
- out_ch  out  SEL_W  channel index of the beat on out_data.
- busy  out  1  high while a packet grant is held (LOCKED state).

Behaviour:
- Reset (asynchronous assert, synchronous deassert at clk):
  - out_valid=0, out_data=0, out_last=0, out_ch=0, busy=0, in_ready=0.
  - State IDLE; round-robin pointer ptr=N_CH-1, so the first RR search starts at channel 0.
- State machine: IDLE, LOCKED.
- IDLE, grant decision (mode and sel are sampled only here):
  - mode=0: grant channel g=sel if sel<N_CH and in_valid[sel]=1. Otherwise remain IDLE.
  - mode=1: grant the first channel with in_valid=1, searching ptr+1, ptr+2, ... with wrap modulo N_CH. If no channel is valid, remain IDLE.
  - On grant: latch g, set busy=1, go to LOCKED next cycle. in_ready stays all-zero in IDLE, so the grant costs one cycle.
- LOCKED:
  - in_ready[g] = (!out_valid || out_ready). All other in_ready bits are 0.
  - Accept when in_valid[g] && in_ready[g]. On accept, at the next edge: out_data<=channel g data, out_last<=in_last[g], out_ch<=g, out_valid<=1.
  - Accepting a beat with in_last[g]=1: next state IDLE, busy<=0, ptr<=g (in both modes).
  - Ungranted channels are ignored while LOCKED, even if valid.
  - mode/sel changes in LOCKED have no effect until the next IDLE.
- Output stage:
  - out_valid clears on out_ready=1 only when no new beat is accepted the same cycle.
  - A simultaneous drain and accept replaces the register contents, giving full throughput of 1 beat/cycle.
  - While out_valid=1 and out_ready=0, out_data/out_last/out_ch hold stable and in_ready[g]=0.
- Latency:
  - Input accept to out_valid: 1 cycle.
  - Packet end to the next grant: 1 cycle (IDLE), then a further cycle to the first in_ready.
  - The previous packet's last beat may still sit in the output register during the next IDLE/grant.
- Boundaries:
  - Single-beat packet (last on the first beat): LOCKED lasts exactly 1 accept.
  - ptr wraps from N_CH-1 to 0.
  - Static sel pointing at an invalid or non-existent channel: no grant, no outputs change.
  - in_valid dropping mid-packet: stay LOCKED, wait with no timeout.
  - Reset mid-packet: all state is cleared immediately and the in-flight output beat is lost.
- Arithmetic: ptr and g are SEL_W-bit; wrap is explicit modulo N_CH, so non-power-of-2 N_CH is correct.

Test Plan:
- Reset check: hold rst_n=0 with all inputs active, then release → out_valid=0, in_ready=0000, busy=0. The first RR grant with in_valid=1111 goes to ch0 (out_ch=0).
- RR fairness: mode=1, in_valid=1111, each channel sends 2-beat packets, out_ready=1 → out_ch sequence is 0,0,1,1,2,2,3,3,0,0.
- Static select: mode=0, sel=2, in_valid=1111, ch2 data 0xA5 then 0x3C with last on the second beat → out_data 0xA5 then 0x3C, out_ch=2, out_last on the second beat only. Channels 0,1,3 get no in_ready.
- Backpressure: ch1 streaming 4 beats with out_ready toggling 1,0,0,1,1,1 → no beat lost or duplicated. out_data holds while out_ready=0, and in_ready[1]=0 during those cycles.
- Packet lock: mode=1, ch0 mid-packet (3 of 5 beats sent) while ch3 asserts valid → ch3 is not granted until ch0's last beat is accepted. The next out_ch is 3.
- Async reset mid-packet: assert rst_n=0 between clock edges while LOCKED on ch2 → out_valid and busy drop immediately without waiting for a clock. After release, the RR search restarts from ch0.
